// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bundle for pipelined_cla_adder.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, s, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, s, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, s, cout);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, s, cout);
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract: one BLOCK-bit CLA slice per stage, carry registered between
// stages, global valid/ready stall. Define PIPE_ADDER_OVF_EN to add the signed-overflow output.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    pipelined_cla_adder_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
    end

    // Returns {carry_out, sum}; every carry is expanded from generate/propagate terms and c0.
    function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             c0);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & c0);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic             adv;
    logic             out_valid;
    logic             v_in [NBLK];
    logic             c_in [NBLK];
    logic [WIDTH-1:0] a_in [NBLK];
    logic [WIDTH-1:0] b_in [NBLK];
    logic [WIDTH-1:0] s_in [NBLK];

    // The whole pipe moves as one; bubbles advance like ops rather than being squeezed out.
    assign adv           = !out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid;

    assign v_in[0] = bus.in_valid;
    assign c_in[0] = bus.cin ^ bus.sub;
    assign a_in[0] = bus.a;
    assign b_in[0] = bus.b ^ {WIDTH{bus.sub}};
    assign s_in[0] = '0;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [BLOCK:0]   res;
        logic [WIDTH-1:0] s_nxt;
        logic             v_q;

        assign res = cla_slice(a_in[k][BLOCK*k +: BLOCK], b_in[k][BLOCK*k +: BLOCK], c_in[k]);

        // NOTE: default the whole vector before patching one slice so no path leaves it unassigned.
        always_comb begin
            s_nxt                   = s_in[k];
            s_nxt[BLOCK*k +: BLOCK] = res[BLOCK-1:0];
        end

        // NOTE: clocked state uses <= so every stage samples its neighbour's pre-edge value.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)    v_q <= 1'b0;
            else if (adv) v_q <= v_in[k];
        end

        if (k < NBLK - 1) begin : g_mid
            logic             c_q;
            logic [WIDTH-1:0] s_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // NOTE: inner data registers have no reset; the valid bit alone decides whether they matter.
            always_ff @(posedge clk) begin
                if (adv) begin
                    c_q <= res[BLOCK];
                    s_q <= s_nxt;
                    a_q <= a_in[k];
                    b_q <= b_in[k];
                end
            end

            assign v_in[k+1] = v_q;
            assign c_in[k+1] = c_q;
            assign s_in[k+1] = s_q;
            assign a_in[k+1] = a_q;
            assign b_in[k+1] = b_q;
        end else begin : g_last
            logic [WIDTH-1:0] s_q;
            logic             cout_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s_q    <= '0;
                    cout_q <= 1'b0;
                end else if (adv) begin
                    s_q    <= s_nxt;
                    cout_q <= res[BLOCK];
                end
            end

            assign out_valid = v_q;
            assign bus.s     = s_q;
            assign bus.cout  = cout_q;

`ifdef PIPE_ADDER_OVF_EN
            logic ovf_q;

            // Operands of equal sign whose sum flips sign; b is already inverted for subtract.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)    ovf_q <= 1'b0;
                else if (adv) ovf_q <= (a_in[k][WIDTH-1] == b_in[k][WIDTH-1]) &&
                                       (s_nxt[WIDTH-1] != a_in[k][WIDTH-1]);
            end

            assign bus.ovf = ovf_q;
`endif
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and random checks of pipelined_cla_adder at W32/B8, W16/B4 and W8/B8 side by side.
// Results are compared in order against hand values or an arithmetic model.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

`ifdef PIPE_ADDER_OVF_EN
    localparam logic [63:0] OVF32 = 64'h2_0000_0000;
`else
    localparam logic [63:0] OVF32 = 64'd0;
`endif

    pipelined_cla_adder_if #(.WIDTH(32)) if0 ();
    pipelined_cla_adder_if #(.WIDTH(16)) if1 ();
    pipelined_cla_adder_if #(.WIDTH(8))  if2 ();

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
    pipelined_cla_adder #(.WIDTH(8),  .BLOCK(8)) dut2 (.clk(clk), .rstn(rstn), .bus(if2));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] q [3][$];
    logic [63:0] nx [3];
    logic [63:0] held [3];
    logic [63:0] obs [3];
    logic [2:0]  stalled, acc, iv, ir, ov, ordy;
    int          sent [3];
    int          bp_sent;
    bit          hold;

    assign iv   = {if2.in_valid,  if1.in_valid,  if0.in_valid};
    assign ir   = {if2.in_ready,  if1.in_ready,  if0.in_ready};
    assign ov   = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign ordy = {if2.out_ready, if1.out_ready, if0.out_ready};
`ifdef PIPE_ADDER_OVF_EN
    assign obs[0] = {30'b0, if0.ovf, if0.cout, if0.s};
    assign obs[1] = {46'b0, if1.ovf, if1.cout, if1.s};
    assign obs[2] = {54'b0, if2.ovf, if2.cout, if2.s};
`else
    assign obs[0] = {31'b0, if0.cout, if0.s};
    assign obs[1] = {47'b0, if1.cout, if1.s};
    assign obs[2] = {55'b0, if2.cout, if2.s};
`endif

    function automatic int width_of(input int i);
        return (i == 0) ? 32 : (i == 1) ? 16 : 8;
    endfunction

    function automatic int nblk_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    // Packed result {ovf, cout, s} for a w-bit unit.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] mask, aa, bb, r;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'b0, a} & mask;
        bb   = ({32'b0, b} ^ {64{sub}}) & mask;
        r    = aa + bb + {63'b0, cin ^ sub};
        model = r & ((mask << 1) | 64'd1);
`ifdef PIPE_ADDER_OVF_EN
        model[w+1] = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        n_checks++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
        end
    endtask

    task automatic set_valid(input int i, input logic v);
        case (i)
            0:       if0.in_valid = v;
            1:       if1.in_valid = v;
            default: if2.in_valid = v;
        endcase
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [63:0] exp_v);
        nx[i] = exp_v;
        case (i)
            0:       begin if0.a = a;       if0.b = b;       if0.cin = cin; if0.sub = sub; end
            1:       begin if1.a = a[15:0]; if1.b = b[15:0]; if1.cin = cin; if1.sub = sub; end
            default: begin if2.a = a[7:0];  if2.b = b[7:0];  if2.cin = cin; if2.sub = sub; end
        endcase
        set_valid(i, 1'b1);
    endtask

    task automatic rnd_op(input int i, input logic v);
        logic [31:0] ra, rb;
        logic        rc, rs;
        ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        rb = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        set_op(i, ra, rb, rc, rs, model(width_of(i), ra, rb, rc, rs));
        set_valid(i, v);
    endtask

    // Observe at the falling edge: scoreboard outputs, hold stability, record accepted inputs.
    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (ov[i] && stalled[i]) check($sformatf("dut%0d held output", i), obs[i], held[i]);
            stalled[i] = ov[i] && !ordy[i];
            held[i]    = obs[i];
            if (ov[i] && ordy[i]) begin
                if (q[i].size() == 0) check($sformatf("dut%0d spurious out_valid", i), {63'b0, ov[i]}, 64'd0);
                else                  check($sformatf("dut%0d result", i), obs[i], q[i].pop_front());
            end
            acc[i] = iv[i] && ir[i];
            if (acc[i]) q[i].push_back(nx[i]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        rstn    = 1'b0;
        stalled = '0;
        acc     = '0;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0; if0.sub = 1'b0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0; if2.sub = 1'b0; if2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d reset out_valid", i), {63'b0, ov[i]}, 64'd0);
            check($sformatf("dut%0d reset outputs", i), obs[i], 64'd0);
            check($sformatf("dut%0d reset in_ready", i), {63'b0, ir[i]}, 64'd1);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        advance();

        // Full carry ripple on all widths, plus latency of 4 / 4 / 1 edges.
        set_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 64'h1_0000_0000);
        set_op(1, 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 64'h0_0001_0000);
        set_op(2, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 64'h0_0000_0100);
        tick();
        for (int i = 0; i < 3; i++) set_valid(i, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            sample();
            for (int i = 0; i < 3; i++)
                check($sformatf("dut%0d out_valid after %0d edges", i, k), {63'b0, ov[i]},
                      {63'b0, k == nblk_of(i)});
            advance();
        end

        // Directed add/subtract/overflow vectors, back to back.
        set_op(0, 32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 64'h0_2222_2221);           tick();
        set_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 64'h0_FFFF_FFFE);           tick();
        set_op(0, 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 64'h1_0000_0006);           tick();
        set_op(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 64'h1_0000_0000);           tick();
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 64'h0_8000_0000 | OVF32);   tick();
        set_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 64'h1_0000_0000 | OVF32);   tick();
        set_valid(0, 1'b0);
        repeat (6) tick();
        check("dut0 directed results outstanding", 64'(q[0].size()), 64'd0);

        // Asynchronous reset with ops in flight and a result on the output.
        for (int n = 0; n < 4; n++) begin
            rnd_op(0, 1'b1);
            tick();
        end
        set_valid(0, 1'b0);
        #2;
        check("dut0 out_valid before reset", {63'b0, ov[0]}, 64'd1);
        rstn = 1'b0;
        #1;
        check("dut0 async reset out_valid", {63'b0, ov[0]}, 64'd0);
        check("dut0 async reset outputs", obs[0], 64'd0);
        check("dut0 async reset in_ready", {63'b0, ir[0]}, 64'd1);
        q[0].delete();
        stalled = '0;
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (8) tick();

        // Ten back-to-back ops with a five-cycle downstream stall.
        bp_sent = 0;
        rnd_op(0, 1'b1);
        for (int c = 0; c < 30; c++) begin
            hold = (c >= 6 && c <= 10);
            if0.out_ready = !hold;
            sample();
            check($sformatf("dut0 in_ready cycle %0d", c), {63'b0, ir[0]}, {63'b0, !hold});
            advance();
            if (acc[0]) begin
                bp_sent++;
                if (bp_sent < 10) rnd_op(0, 1'b1);
                else              set_valid(0, 1'b0);
            end
        end
        check("dut0 backpressure ops accepted", 64'(bp_sent), 64'd10);
        check("dut0 backpressure results outstanding", 64'(q[0].size()), 64'd0);

        // Random traffic and random backpressure on all three units.
        for (int i = 0; i < 3; i++) begin
            sent[i] = 0;
            rnd_op(i, $urandom_range(0, 4) != 0);
        end
        for (int c = 0; c < 4000 && !(sent[1] >= 1000 && sent[2] >= 1000); c++) begin
            if0.out_ready = ($urandom_range(0, 4) != 0);
            if1.out_ready = ($urandom_range(0, 4) != 0);
            if2.out_ready = ($urandom_range(0, 4) != 0);
            tick();
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) sent[i]++;
                rnd_op(i, $urandom_range(0, 4) != 0);
            end
        end
        for (int i = 0; i < 3; i++) set_valid(i, 1'b0);
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        if2.out_ready = 1'b1;
        repeat (10) tick();
        check("dut1 random ops accepted", 64'(sent[1] >= 1000), 64'd1);
        check("dut2 random ops accepted", 64'(sent[2] >= 1000), 64'd1);
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d random results outstanding", i), 64'(q[i].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
